// File: rtl/bist_boot_sequencer.sv
// Sequences LBIST -> settle -> firmware load -> core reset release for the RI5CY wrapper.
// Optional BIST watchdog enabled by defining BIST_TIMEOUT_EN.
module bist_boot_sequencer #(
  parameter int unsigned SETTLE_CYCLES     = 15,
  parameter int unsigned RESET_WAIT_CYCLES = 4,
  parameter int unsigned BIST_TIMEOUT      = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bist_start_i,
  input  logic       bist_done_i,
  input  logic       bist_go_nogo_i,
  input  logic       load_done_i,
  output logic       bist_en_o,
  output logic       load_req_o,
  output logic       core_clk_en_o,
  output logic       core_rst_no,
  output logic       fetch_enable_o,
  output logic       fail_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BIST   = 3'd1,
    S_SETTLE = 3'd2,
    S_LOAD   = 3'd3,
    S_CRST   = 3'd4,
    S_RUN    = 3'd5,
    S_FAIL   = 3'd6
  } state_e;

  localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] RstLoad    = 16'(RESET_WAIT_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 || RESET_WAIT_CYCLES < 1 ||
      RESET_WAIT_CYCLES > 65535 || BIST_TIMEOUT < 1) begin : g_bad_param
    $error("bist_boot_sequencer: parameter out of range");
  end

`ifdef BIST_TIMEOUT_EN
  // The shared counter is 16 bits wide; longer timeouts saturate at its full range.
  localparam int unsigned TimeoutClamp = (BIST_TIMEOUT > 65536) ? 65536 : BIST_TIMEOUT;
  localparam logic [15:0] TimeoutLoad  = 16'(TimeoutClamp - 1);
  logic timeout_hit;
  logic timeout_q, timeout_d;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bist_en_q, bist_en_d;
  logic        load_req_q, load_req_d;
  logic        core_clk_en_q, core_clk_en_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        fetch_enable_q, fetch_enable_d;
  logic        fail_q, fail_d;

  // NOTE: synchronous reset lives inside the clocked block; all state uses <= so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      cnt_q          <= 16'd0;
      bist_en_q      <= 1'b0;
      load_req_q     <= 1'b0;
      core_clk_en_q  <= 1'b0;
      core_rst_n_q   <= 1'b0;
      fetch_enable_q <= 1'b0;
      fail_q         <= 1'b0;
`ifdef BIST_TIMEOUT_EN
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bist_en_q      <= bist_en_d;
      load_req_q     <= load_req_d;
      core_clk_en_q  <= core_clk_en_d;
      core_rst_n_q   <= core_rst_n_d;
      fetch_enable_q <= fetch_enable_d;
      fail_q         <= fail_d;
`ifdef BIST_TIMEOUT_EN
      timeout_q      <= timeout_d;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef BIST_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bist_start_i) begin
          state_d = S_BIST;
`ifdef BIST_TIMEOUT_EN
          cnt_d   = TimeoutLoad;
`endif
        end
      end
      S_BIST: begin
        // A done pulse takes priority over a watchdog expiry in the same cycle.
        if (bist_done_i) begin
          if (bist_go_nogo_i) begin
            state_d = S_SETTLE;
            cnt_d   = SettleLoad;
          end else begin
            state_d = S_FAIL;
          end
        end
`ifdef BIST_TIMEOUT_EN
        else if (cnt_q == 16'd0) begin
          state_d     = S_FAIL;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
`endif
      end
      S_SETTLE: begin
        if (cnt_q == 16'd0) begin
          state_d = bist_go_nogo_i ? S_LOAD : S_FAIL;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_LOAD: begin
        if (load_done_i) begin
          state_d = S_CRST;
          cnt_d   = RstLoad;
        end
      end
      S_CRST: begin
        if (cnt_q == 16'd0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RUN, S_FAIL: state_d = state_q;
      default:       state_d = S_FAIL;
    endcase
  end

  // Outputs decode the next state so they flip on the same edge as the state.
  always_comb begin
    bist_en_d      = 1'b0;
    load_req_d     = 1'b0;
    core_clk_en_d  = 1'b0;
    core_rst_n_d   = 1'b0;
    fetch_enable_d = 1'b0;
    fail_d         = 1'b0;
    case (state_d)
      S_BIST: bist_en_d = 1'b1;
      S_LOAD: load_req_d = 1'b1;
      S_CRST: core_clk_en_d = 1'b1;
      S_RUN: begin
        core_clk_en_d  = 1'b1;
        core_rst_n_d   = 1'b1;
        fetch_enable_d = 1'b1;
      end
      S_FAIL:  fail_d = 1'b1;
      default: ;
    endcase
`ifdef BIST_TIMEOUT_EN
    timeout_d = (state_d == S_FAIL) && (timeout_q || timeout_hit);
`endif
  end

  assign bist_en_o      = bist_en_q;
  assign load_req_o     = load_req_q;
  assign core_clk_en_o  = core_clk_en_q;
  assign core_rst_no    = core_rst_n_q;
  assign fetch_enable_o = fetch_enable_q;
  assign fail_o         = fail_q;
  assign state_o        = state_q;
`ifdef BIST_TIMEOUT_EN
  assign timeout_o      = timeout_q;
`else
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_bist_boot_sequencer.sv
// Directed bench for bist_boot_sequencer: expectations are queued per cycle by the
// stimulus thread and compared by an independent monitor on the falling edge.
module tb_bist_boot_sequencer;

  // Output vector order: {bist_en, load_req, core_clk_en, core_rst_n, fetch_en, fail, timeout}
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_BIST = 7'b1000000;
  localparam logic [6:0] O_LOAD = 7'b0100000;
  localparam logic [6:0] O_CRST = 7'b0010000;
  localparam logic [6:0] O_RUN  = 7'b0011100;
  localparam logic [6:0] O_FAIL = 7'b0000010;
  localparam logic [6:0] O_TO   = 7'b0000011;

  typedef struct {
    int         cyc;
    int         inst;
    logic [2:0] st;
    logic [6:0] outs;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start_1 = 1'b0;
  logic done = 1'b0, go = 1'b0, load_done = 1'b0;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  exp_t sb[$];

  logic       bist_en [2];
  logic       load_req [2];
  logic       clk_en [2];
  logic       core_rst_n [2];
  logic       fetch_en [2];
  logic       fail_f [2];
  logic       to_f [2];
  logic [2:0] st [2];

  bist_boot_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .bist_start_i(start), .bist_done_i(done),
    .bist_go_nogo_i(go), .load_done_i(load_done), .bist_en_o(bist_en[0]),
    .load_req_o(load_req[0]), .core_clk_en_o(clk_en[0]), .core_rst_no(core_rst_n[0]),
    .fetch_enable_o(fetch_en[0]), .fail_o(fail_f[0]), .timeout_o(to_f[0]), .state_o(st[0])
  );

  bist_boot_sequencer #(.BIST_TIMEOUT(8)) dut_to (
    .clk_i(clk), .rst_ni(rst_n), .bist_start_i(start_1), .bist_done_i(done),
    .bist_go_nogo_i(go), .load_done_i(load_done), .bist_en_o(bist_en[1]),
    .load_req_o(load_req[1]), .core_clk_en_o(clk_en[1]), .core_rst_no(core_rst_n[1]),
    .fetch_enable_o(fetch_en[1]), .fail_o(fail_f[1]), .timeout_o(to_f[1]), .state_o(st[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int c, input int inst, input logic [2:0] s,
                           input logic [6:0] o, input string name);
    exp_t e;
    e.cyc = c; e.inst = inst; e.st = s; e.outs = o; e.name = name;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
               name, cyc, act[9:7], act[6:0], req[9:7], req[6:0]);
    end
  endtask

  // Monitor: compares every queued expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      int   i;
      e = sb.pop_front();
      i = e.inst;
      if (e.cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed, now at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        check(e.name,
              {st[i], bist_en[i], load_req[i], clk_en[i], core_rst_n[i], fetch_en[i], fail_f[i], to_f[i]},
              {e.st, e.outs});
      end
    end
  end

  initial begin
    // Nominal pass with default parameters
    goto(1);   rst_n = 1'b1;
    expect_at(1, 0, 3'd0, O_IDLE, "reset_state");
    expect_at(1, 1, 3'd0, O_IDLE, "reset_state_to_inst");
    goto(2);   start = 1'b1;
    expect_at(2, 0, 3'd0, O_IDLE, "idle_before_start");
    goto(3);   start = 1'b0;
    expect_at(3, 0, 3'd1, O_BIST, "bist_en_first");
    goto(20);  done = 1'b1; go = 1'b1;
    expect_at(20, 0, 3'd1, O_BIST, "bist_en_last");
    goto(21);  done = 1'b0;
    expect_at(21, 0, 3'd2, O_IDLE, "settle_first");
    expect_at(35, 0, 3'd2, O_IDLE, "settle_last");
    expect_at(36, 0, 3'd3, O_LOAD, "load_req_first");
    goto(40);  load_done = 1'b1;
    expect_at(40, 0, 3'd3, O_LOAD, "load_req_held");
    goto(41);  load_done = 1'b0;
    expect_at(41, 0, 3'd4, O_CRST, "crst_first");
    expect_at(44, 0, 3'd4, O_CRST, "crst_last");
    expect_at(45, 0, 3'd5, O_RUN, "run_first");
    // Start pulse while in RUN is ignored
    goto(46);  start = 1'b1;
    goto(47);  start = 1'b0;
    expect_at(47, 0, 3'd5, O_RUN, "run_ignore_start");
    expect_at(48, 0, 3'd5, O_RUN, "run_still");

    // BIST verdict fail
    goto(50);  rst_n = 1'b0; go = 1'b0;
    goto(51);  rst_n = 1'b1;
    expect_at(51, 0, 3'd0, O_IDLE, "reset_from_run");
    goto(52);  start = 1'b1;
    goto(53);  start = 1'b0;
    expect_at(53, 0, 3'd1, O_BIST, "bist_second");
    goto(55);  done = 1'b1; go = 1'b0;
    goto(56);  done = 1'b0;
    expect_at(56, 0, 3'd6, O_FAIL, "fail_verdict");
    expect_at(60, 0, 3'd6, O_FAIL, "fail_sticky");

    // Verdict drops on the last SETTLE cycle
    goto(62);  rst_n = 1'b0;
    goto(63);  rst_n = 1'b1;
    expect_at(63, 0, 3'd0, O_IDLE, "reset_from_fail");
    goto(64);  start = 1'b1;
    goto(65);  start = 1'b0;
    goto(66);  done = 1'b1; go = 1'b1;
    goto(67);  done = 1'b0;
    expect_at(67, 0, 3'd2, O_IDLE, "settle_third");
    expect_at(80, 0, 3'd2, O_IDLE, "settle_penult");
    goto(81);  go = 1'b0;
    goto(82);
    expect_at(82, 0, 3'd6, O_FAIL, "fail_verdict_drop");
    expect_at(83, 0, 3'd6, O_FAIL, "fail_drop_sticky");

    // Early acknowledge ignored, then reset mid-CRST and a full re-run
    goto(84);  rst_n = 1'b0; go = 1'b1;
    goto(85);  rst_n = 1'b1;
    expect_at(85, 0, 3'd0, O_IDLE, "reset_from_fail2");
    goto(86);  start = 1'b1;
    goto(87);  start = 1'b0;
    goto(88);  done = 1'b1;
    goto(89);  done = 1'b0;
    goto(103); load_done = 1'b1;
    expect_at(103, 0, 3'd2, O_IDLE, "settle_with_early_ack");
    goto(104); load_done = 1'b0;
    expect_at(104, 0, 3'd3, O_LOAD, "load_entry");
    expect_at(106, 0, 3'd3, O_LOAD, "early_ack_ignored");
    goto(106); load_done = 1'b1;
    goto(107); load_done = 1'b0;
    expect_at(107, 0, 3'd4, O_CRST, "crst_before_reset");
    goto(108); rst_n = 1'b0;
    goto(109); rst_n = 1'b1;
    expect_at(109, 0, 3'd0, O_IDLE, "reset_mid_crst");
    goto(110); start = 1'b1;
    goto(111); start = 1'b0;
    expect_at(111, 0, 3'd1, O_BIST, "rerun_bist");
    goto(112); done = 1'b1;
    goto(113); done = 1'b0;
    expect_at(113, 0, 3'd2, O_IDLE, "rerun_settle");
    expect_at(127, 0, 3'd2, O_IDLE, "rerun_settle_last");
    expect_at(128, 0, 3'd3, O_LOAD, "rerun_load");
    goto(128); load_done = 1'b1;
    goto(129); load_done = 1'b0;
    expect_at(129, 0, 3'd4, O_CRST, "rerun_crst");
    expect_at(132, 0, 3'd4, O_CRST, "rerun_crst_last");
    expect_at(133, 0, 3'd5, O_RUN, "rerun_run");

    // BIST watchdog on the instance built with BIST_TIMEOUT=8
    goto(135); rst_n = 1'b0;
    goto(136); rst_n = 1'b1;
    expect_at(136, 0, 3'd0, O_IDLE, "reset_before_timeout");
    expect_at(136, 1, 3'd0, O_IDLE, "to_inst_idle");
    goto(137); start_1 = 1'b1;
    goto(138); start_1 = 1'b0;
    expect_at(138, 1, 3'd1, O_BIST, "to_inst_bist");
`ifdef BIST_TIMEOUT_EN
    expect_at(145, 1, 3'd1, O_BIST, "to_last_bist_cycle");
    expect_at(146, 1, 3'd6, O_TO, "timeout_fail");
    expect_at(150, 1, 3'd6, O_TO, "timeout_sticky");
`else
    expect_at(146, 1, 3'd1, O_BIST, "no_timeout");
    expect_at(160, 1, 3'd1, O_BIST, "no_timeout_late");
`endif
    expect_at(160, 0, 3'd0, O_IDLE, "main_idle_late");

    goto(165);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
